// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle synchronous instruction
// memory and presents {IF_inst, IF_pc, IF_vld} to the IF/ID register.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ID_jmp_vld,
  input  logic [31:0] ID_pc,
  input  logic [31:0] ID_imm,
  input  logic        EX_br_vld,
  input  logic [31:0] EX_br_addr,
  output logic [31:0] imem_addr,
  output logic        imem_en,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc,
  output logic        IF_vld
);

  logic [31:0] r_pc_f;
  logic [31:0] r_pc_d;
  logic        r_vld_d;
  logic [31:0] r_hold_inst;
  logic        r_hold_vld;

  logic        w_jal_take;
  logic [31:0] w_jal_target;

  // A JAL seen while stalled is dropped; ID re-asserts it once the stall clears.
  assign w_jal_take   = ID_jmp_vld & ~stall;
  assign w_jal_target = (ID_pc + ID_imm) & ~32'd3;

  assign imem_addr = {r_pc_f[31:2], 2'b00};
  assign imem_en   = ~rst & (~stall | EX_br_vld);

  assign IF_pc   = r_pc_d;
  assign IF_vld  = r_vld_d & ~EX_br_vld & ~w_jal_take;
  assign IF_inst = !r_vld_d   ? INST_NOP :
                   r_hold_vld ? r_hold_inst : imem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f      <= RESET_PC;
      r_pc_d      <= RESET_PC;
      r_vld_d     <= 1'b0;
      r_hold_vld  <= 1'b0;
      r_hold_inst <= INST_NOP;
    end else if (EX_br_vld) begin
      r_pc_f     <= EX_br_addr & ~32'd3;
      r_vld_d    <= 1'b0;
      r_hold_vld <= 1'b0;
    end else if (w_jal_take) begin
      r_pc_f     <= w_jal_target;
      r_vld_d    <= 1'b0;
      r_hold_vld <= 1'b0;
    end else if (stall) begin
      // Memory is not re-read during a stall, so capture the returning word once.
      if (!r_hold_vld) begin
        r_hold_inst <= imem_rdata;
        r_hold_vld  <= 1'b1;
      end
    end else begin
      r_pc_d     <= r_pc_f;
      r_vld_d    <= 1'b1;
      r_pc_f     <= r_pc_f + 32'd4;
      r_hold_vld <= 1'b0;
    end
  end

endmodule
